aes_block_loader: RTL and testbench
===================================

AES_BLOCK_LOADER -- requirements
Module: aes_block_loader

Interface
REQ-001 SHALL have parameter PAD_EN, default 1: 1 = PKCS#7 padding; 0 = zero padding with no extra block.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port in_data, input, 8, the incoming byte.
REQ-005 SHALL have port in_valid, input, 1, meaning in_data is valid.
REQ-006 SHALL have port in_ready, output, 1; a byte is accepted on any edge where in_valid and in_ready are both 1.
REQ-007 SHALL have port in_last, input, 1, marking the final message byte; it is ignored for key bytes.
REQ-008 SHALL have port in_is_key, input, 1: 1 = the byte belongs to the key, 0 = the byte belongs to the plaintext.
REQ-009 SHALL have port key_out, output, 128, the assembled AES-128 key.
REQ-010 SHALL have port key_valid, output, 1, a one-cycle pulse when key_out updates.
REQ-011 SHALL have port blk_out, output, 128, the plaintext block for the AES core.
REQ-012 SHALL have port blk_valid, output, 1, and port blk_ready, input, 1; the block transfers on any edge where both are 1.
REQ-013 SHALL have port blk_last, output, 1, meaning blk_out is the final block of the message.
REQ-014 SHALL have port err, output, 1, a sticky protocol-error flag.

Function
REQ-015 SHALL use states FILL, PAD, XPAD and HOLD.
REQ-016 SHALL drive in_ready=1 only in FILL and blk_valid=1 only in HOLD.
REQ-017 SHALL pack bytes MSB-first: the first byte goes to [127:120] and the 16th byte to [7:0]; this applies to both key and data.
REQ-018 SHALL count accepted data bytes with dcnt (0..16) and key bytes with kcnt (0..16).
REQ-019 SHALL, when the 16th key byte is accepted: update key_out, pulse key_valid on the next cycle, set kcnt=0, and not change state.
REQ-020 SHALL, when the 16th data byte is accepted with in_last=0, enter HOLD with blk_last=0.
REQ-021 SHALL, when the 16th data byte is accepted with in_last=1 and PAD_EN=1, enter HOLD with blk_last=0 and set pend_xpad.
REQ-022 SHALL, when the 16th data byte is accepted with in_last=1 and PAD_EN=0, enter HOLD with blk_last=1.
REQ-023 SHALL, when data byte n (n<16) is accepted with in_last=1, enter PAD.
REQ-024 SHALL, in PAD, write one pad byte per cycle at position dcnt and increment dcnt; the pad value is 16-n when PAD_EN=1 and 0x00 when PAD_EN=0.
REQ-025 SHALL enter HOLD with blk_last=1 on the edge that writes byte 15, so blk_valid rises 16-n cycles after the last byte is accepted.
REQ-026 SHALL, on the HOLD handshake, clear dcnt and go to XPAD if pend_xpad is set, otherwise to FILL.
REQ-027 SHALL, in XPAD, load blk_out with all-0x10 bytes and blk_last=1, clear pend_xpad, and enter HOLD after one cycle.
REQ-028 SHALL hold blk_out, blk_last and blk_valid stable in HOLD until the handshake completes, with no time limit.
REQ-029 SHALL, when in_is_key=1 is accepted while dcnt!=0, drop the byte, set err, and leave dcnt and state unchanged.
REQ-030 SHALL, when in_is_key=0 is accepted while kcnt!=0, drop the byte, set err, and leave kcnt and state unchanged.
REQ-031 SHALL clear err only on reset.
REQ-032 SHALL never let a counter exceed 16; counters return to 0 only via REQ-019 or REQ-026.

Reset
REQ-033 SHALL, while rst_n=0 and immediately without waiting for a clock, set all outputs to 0, including in_ready, key_out and blk_out.
REQ-034 SHALL, while rst_n=0, clear dcnt, kcnt and pend_xpad and force state to FILL.
REQ-035 SHALL drive in_ready=1 from the first cycle after reset release.
REQ-036 SHALL discard any partial key or block on reset, including a reset in the middle of PAD or HOLD, and never emit it afterwards.

Verification
REQ-037 Key bytes 00..0f with in_is_key=1 -> key_valid pulses once and key_out=000102030405060708090a0b0c0d0e0f.
REQ-038 PAD_EN=1; data bytes 00,11,..,ff with in_last on the 16th -> blk_out=00112233445566778899aabbccddeeff with blk_last=0, then blk_out=1010..10 with blk_last=1.
REQ-039 PAD_EN=1; data bytes aa,bb,cc with in_last on cc -> 13 PAD cycles, then blk_out=aabbcc followed by thirteen 0d bytes, blk_last=1, and no extra block.
REQ-040 blk_ready=0 for 20 cycles in HOLD -> blk_out stable and in_ready=0 throughout; after blk_ready=1 handshake, in_ready=1 on the next cycle.
REQ-041 5 data bytes then one byte with in_is_key=1 -> err=1, dcnt=5, and after 11 more data bytes the block contains only data bytes.
REQ-042 rst_n low after 7 data bytes -> outputs 0 at once; after release, 16 new bytes produce a block holding only the new bytes.
REQ-043 PAD_EN=0; byte 5a with in_last=1 -> blk_out=5a followed by fifteen 00 bytes, blk_last=1, and no extra block.

Source files
------------

// File: rtl/aes_block_loader.sv
// Byte-stream loader for an AES-128 core: assembles 16-byte keys and plaintext
// blocks MSB-first, pads the final block (PKCS#7 or zeros) and hands blocks off.
module aes_block_loader #(
  parameter int PAD_EN = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_last,
  input  logic         in_is_key,
  output logic [127:0] key_out,
  output logic         key_valid,
  output logic [127:0] blk_out,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic         blk_last,
  output logic         err
);

  localparam logic [1:0] FILL = 2'd0;
  localparam logic [1:0] PAD  = 2'd1;
  localparam logic [1:0] XPAD = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  localparam bit PKCS = (PAD_EN != 0);

  logic [1:0]   state;
  logic [4:0]   dcnt;
  logic [4:0]   kcnt;
  logic         pend_xpad;
  logic         run;
  logic [7:0]   pad_val;
  logic [127:0] key_acc;

  // Byte n lands at bit offset 8*(15-n); the 4-bit complement gives 15-n.
  logic [6:0] dpos;
  logic [6:0] kpos;
  logic       in_fire;

  assign dpos    = {~dcnt[3:0], 3'b000};
  assign kpos    = {~kcnt[3:0], 3'b000};
  assign in_fire = in_valid && in_ready;

  // run keeps in_ready low until the first edge after reset release.
  assign in_ready  = run && (state == FILL);
  assign blk_valid = (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      dcnt      <= 5'd0;
      kcnt      <= 5'd0;
      pend_xpad <= 1'b0;
      run       <= 1'b0;
      pad_val   <= 8'd0;
      key_acc   <= 128'd0;
      key_out   <= 128'd0;
      key_valid <= 1'b0;
      blk_out   <= 128'd0;
      blk_last  <= 1'b0;
      err       <= 1'b0;
    end else begin
      run       <= 1'b1;
      key_valid <= 1'b0;
      case (state)
        FILL: begin
          if (in_fire) begin
            if (in_is_key) begin
              if (dcnt != 5'd0) begin
                err <= 1'b1;
              end else if (kcnt == 5'd15) begin
                key_out   <= {key_acc[127:8], in_data};
                key_valid <= 1'b1;
                kcnt      <= 5'd0;
              end else begin
                key_acc[kpos +: 8] <= in_data;
                kcnt               <= kcnt + 5'd1;
              end
            end else if (kcnt != 5'd0) begin
              err <= 1'b1;
            end else begin
              blk_out[dpos +: 8] <= in_data;
              dcnt               <= dcnt + 5'd1;
              if (dcnt == 5'd15) begin
                state     <= HOLD;
                blk_last  <= in_last && !PKCS;
                pend_xpad <= in_last && PKCS;
              end else if (in_last) begin
                state   <= PAD;
                pad_val <= PKCS ? 8'(5'd15 - dcnt) : 8'd0;
              end
            end
          end
        end
        PAD: begin
          blk_out[dpos +: 8] <= pad_val;
          dcnt               <= dcnt + 5'd1;
          if (dcnt == 5'd15) begin
            state    <= HOLD;
            blk_last <= 1'b1;
          end
        end
        XPAD: begin
          // A full final block under PKCS#7 needs a whole block of 0x10 after it.
          blk_out   <= {16{8'h10}};
          blk_last  <= 1'b1;
          pend_xpad <= 1'b0;
          state     <= HOLD;
        end
        default: begin
          if (blk_ready) begin
            dcnt  <= 5'd0;
            state <= pend_xpad ? XPAD : FILL;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed bench for aes_block_loader: PKCS#7 instance plus a zero-padding instance.
module tb_aes_block_loader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   in_data = 8'd0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_last = 1'b0;
  logic         in_is_key = 1'b0;
  logic [127:0] key_out;
  logic         key_valid;
  logic [127:0] blk_out;
  logic         blk_valid;
  logic         blk_ready = 1'b0;
  logic         blk_last;
  logic         err;

  logic [7:0]   in_data_z = 8'd0;
  logic         in_valid_z = 1'b0;
  logic         in_ready_z;
  logic         in_last_z = 1'b0;
  logic [127:0] key_out_z;
  logic         key_valid_z;
  logic [127:0] blk_out_z;
  logic         blk_valid_z;
  logic         blk_ready_z = 1'b0;
  logic         blk_last_z;
  logic         err_z;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  aes_block_loader #(.PAD_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .in_is_key(in_is_key),
    .key_out(key_out), .key_valid(key_valid), .blk_out(blk_out),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_last(blk_last), .err(err)
  );

  aes_block_loader #(.PAD_EN(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_z), .in_valid(in_valid_z),
    .in_ready(in_ready_z), .in_last(in_last_z), .in_is_key(1'b0),
    .key_out(key_out_z), .key_valid(key_valid_z), .blk_out(blk_out_z),
    .blk_valid(blk_valid_z), .blk_ready(blk_ready_z), .blk_last(blk_last_z), .err(err_z)
  );

  // Offers one byte and returns at posedge+1 after it was accepted.
  task automatic send(input logic [7:0] d, input logic last, input logic is_key);
    int waited;
    @(negedge clk);
    in_data = d; in_last = last; in_is_key = is_key; in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      compared++; mismatched++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0; in_is_key = 1'b0;
  endtask

  task automatic wait_blk(output int cycles);
    cycles = 0;
    while (!blk_valid && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (!blk_valid) begin
      compared++; mismatched++;
      $display("FAIL blk_timeout: blk_valid=%0b required 1", blk_valid);
    end
  endtask

  task automatic take();
    blk_ready = 1'b1;
    @(posedge clk); #1;
    blk_ready = 1'b0;
  endtask

  task automatic check_idle(input string name);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      compared++;
      if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin
        mismatched++;
        $display("FAIL %s: blk_valid=%0b in_ready=%0b required 0/1", name, blk_valid, in_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    compared++;
    if (in_ready !== 1'b0 || key_out !== 128'd0 || blk_out !== 128'd0 || blk_valid !== 1'b0 ||
        key_valid !== 1'b0 || blk_last !== 1'b0 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: rdy=%0b key=%h blk=%h bv=%0b kv=%0b last=%0b err=%0b required all 0",
               in_ready, key_out, blk_out, blk_valid, key_valid, blk_last, err);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_release_ready: in_ready=%0b required 1", in_ready);
    end
    $display("reset: done");
  endtask

  task automatic test_key();
    int pulses;
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 1'b1);
    compared++;
    if (key_valid !== 1'b1 || key_out !== 128'h000102030405060708090a0b0c0d0e0f) begin
      mismatched++;
      $display("FAIL key_load: kv=%0b key=%h required 1/000102030405060708090a0b0c0d0e0f", key_valid, key_out);
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (key_valid) pulses++;
    end
    compared++;
    if (pulses != 0) begin
      mismatched++;
      $display("FAIL key_pulse_width: extra pulses=%0d required 0", pulses);
    end
    $display("key: key_out=%h", key_out);
  endtask

  task automatic test_pad_full();
    int cyc;
    for (int i = 0; i < 16; i++) send(8'(i * 17), (i == 15), 1'b0);
    wait_blk(cyc);
    compared++;
    if (blk_out !== 128'h00112233445566778899aabbccddeeff || blk_last !== 1'b0) begin
      mismatched++;
      $display("FAIL full_block: blk=%h last=%0b required 00112233445566778899aabbccddeeff/0", blk_out, blk_last);
    end
    take();
    wait_blk(cyc);
    compared++;
    if (blk_out !== {16{8'h10}} || blk_last !== 1'b1 || cyc != 1) begin
      mismatched++;
      $display("FAIL xpad_block: blk=%h last=%0b cyc=%0d required 1010..10/1/1", blk_out, blk_last, cyc);
    end
    take();
    check_idle("xpad_no_extra");
    $display("pad_full: extra block %h", {16{8'h10}});
  endtask

  task automatic test_pad_short();
    int cyc;
    send(8'haa, 1'b0, 1'b0);
    send(8'hbb, 1'b0, 1'b0);
    send(8'hcc, 1'b1, 1'b0);
    wait_blk(cyc);
    compared++;
    if (cyc != 13 || blk_out !== 128'haabbcc0d0d0d0d0d0d0d0d0d0d0d0d0d || blk_last !== 1'b1) begin
      mismatched++;
      $display("FAIL pad_short: cyc=%0d blk=%h last=%0b required 13/aabbcc0d..0d/1", cyc, blk_out, blk_last);
    end
    take();
    check_idle("pad_short_no_extra");
    $display("pad_short: blk valid after %0d cycles", cyc);
  endtask

  task automatic test_hold_stall();
    int cyc;
    logic [127:0] exp_blk;
    exp_blk = 128'd0;
    for (int i = 0; i < 16; i++) begin
      send(8'(8'h40 + i), 1'b0, 1'b0);
      exp_blk = {exp_blk[119:0], 8'(8'h40 + i)};
    end
    wait_blk(cyc);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      compared++;
      if (blk_out !== exp_blk || blk_valid !== 1'b1 || in_ready !== 1'b0 || blk_last !== 1'b0) begin
        mismatched++;
        $display("FAIL hold_stall: cyc=%0d blk=%h bv=%0b rdy=%0b required %h/1/0", i, blk_out, blk_valid, in_ready, exp_blk);
      end
    end
    take();
    compared++;
    if (in_ready !== 1'b1 || blk_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL hold_release: rdy=%0b bv=%0b required 1/0", in_ready, blk_valid);
    end
    $display("hold_stall: block %h held 20 cycles", exp_blk);
  endtask

  task automatic test_key_in_data();
    int cyc;
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b0, 1'b0);
    send(8'h99, 1'b0, 1'b1);
    compared++;
    if (err !== 1'b1 || dut.dcnt !== 5'd5) begin
      mismatched++;
      $display("FAIL key_in_data_err: err=%0b dcnt=%0d required 1/5", err, dut.dcnt);
    end
    for (int i = 6; i <= 16; i++) send(8'(i), 1'b0, 1'b0);
    wait_blk(cyc);
    compared++;
    if (blk_out !== 128'h0102030405060708090a0b0c0d0e0f10 || blk_last !== 1'b0 || err !== 1'b1) begin
      mismatched++;
      $display("FAIL key_in_data_blk: blk=%h last=%0b err=%0b required 0102..10/0/1", blk_out, blk_last, err);
    end
    take();
    $display("key_in_data: err=%0b", err);
  endtask

  task automatic test_mid_reset();
    int cyc;
    for (int i = 0; i < 7; i++) send(8'hee, 1'b0, 1'b0);
    #2; rst_n = 1'b0;
    #1;
    compared++;
    if (in_ready !== 1'b0 || blk_out !== 128'd0 || err !== 1'b0 || key_out !== 128'd0 || blk_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_reset_outputs: rdy=%0b blk=%h err=%0b key=%h bv=%0b required all 0",
               in_ready, blk_out, err, key_out, blk_valid);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 16; i++) send(8'(8'hf0 + i), 1'b0, 1'b0);
    wait_blk(cyc);
    compared++;
    if (blk_out !== 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff || blk_last !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_reset_blk: blk=%h last=%0b required f0f1..ff/0", blk_out, blk_last);
    end
    take();
    $display("mid_reset: new block %h", blk_out);
  endtask

  task automatic test_data_in_key();
    send(8'hc1, 1'b0, 1'b1);
    send(8'hc2, 1'b0, 1'b1);
    send(8'hc3, 1'b0, 1'b1);
    send(8'h55, 1'b1, 1'b0);
    compared++;
    if (err !== 1'b1 || dut.kcnt !== 5'd3 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL data_in_key_err: err=%0b kcnt=%0d rdy=%0b required 1/3/1", err, dut.kcnt, in_ready);
    end
    for (int i = 3; i < 16; i++) send(8'(8'hc1 + i), 1'b0, 1'b1);
    compared++;
    if (key_valid !== 1'b1 || key_out !== 128'hc1c2c3c4c5c6c7c8c9cacbcccdcecfd0) begin
      mismatched++;
      $display("FAIL data_in_key_key: kv=%0b key=%h required 1/c1c2..d0", key_valid, key_out);
    end
    $display("data_in_key: key=%h err=%0b", key_out, err);
  endtask

  task automatic test_zero_pad();
    int cyc;
    @(negedge clk);
    in_data_z = 8'h5a; in_last_z = 1'b1; in_valid_z = 1'b1;
    cyc = 0;
    while (!in_ready_z && cyc < 50) begin @(negedge clk); cyc++; end
    @(posedge clk); #1;
    in_valid_z = 1'b0; in_last_z = 1'b0;
    cyc = 0;
    while (!blk_valid_z && cyc < 100) begin @(posedge clk); #1; cyc++; end
    compared++;
    if (cyc != 15 || blk_out_z !== 128'h5a000000000000000000000000000000 || blk_last_z !== 1'b1) begin
      mismatched++;
      $display("FAIL zero_pad: cyc=%0d blk=%h last=%0b required 15/5a00..00/1", cyc, blk_out_z, blk_last_z);
    end
    blk_ready_z = 1'b1;
    @(posedge clk); #1;
    blk_ready_z = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      compared++;
      if (blk_valid_z !== 1'b0 || in_ready_z !== 1'b1) begin
        mismatched++;
        $display("FAIL zero_pad_no_extra: bv=%0b rdy=%0b required 0/1", blk_valid_z, in_ready_z);
      end
    end
    $display("zero_pad: blk=%h", blk_out_z);
  endtask

  initial begin
    test_reset();
    test_key();
    test_pad_full();
    test_pad_short();
    test_hold_stall();
    test_key_in_data();
    test_mid_reset();
    test_data_in_key();
    test_zero_pad();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
